// File: rtl/dice_roll_scheduler.sv
// Round-robin arbiter sharing one dice roller between players.
// Runs a timed tumble on the display, then commits and reports the roll.
module dice_roll_scheduler #(
  parameter int NUM_PLAYERS  = 4,
  parameter int TUMBLE_STEPS = 16,
  parameter int TUMBLE_DIV   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_PLAYERS-1:0] roll_req,
  input  logic [2:0]             die_sel,
  output logic                   busy,
  output logic [NUM_PLAYERS-1:0] grant,
  output logic [3:0]             tens,
  output logic [3:0]             ones,
  output logic [4:0]             result,
  output logic                   result_valid,
  output logic [1:0]             result_player
);

  localparam int TW = (TUMBLE_DIV > 1) ? $clog2(TUMBLE_DIV) : 1;
  localparam int SW = (TUMBLE_STEPS > 1) ? $clog2(TUMBLE_STEPS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TUMBLE_DIV - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(TUMBLE_STEPS - 1);
  localparam logic [NUM_PLAYERS-1:0] ONE = 1;
  localparam logic [2:0] NP = 3'(NUM_PLAYERS);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TUMBLE,
    DONE
  } state_t;

  state_t                 state;
  logic [NUM_PLAYERS-1:0] pending;
  logic [NUM_PLAYERS-1:0] req_prev;
  logic [1:0]             rr_ptr;
  logic [4:0]             roll_cnt;
  logic [4:0]             max_r;
  logic [4:0]             disp;
  logic [TW-1:0]          tick;
  logic [SW-1:0]          step;

  logic [NUM_PLAYERS-1:0] req_edge;
  logic [NUM_PLAYERS-1:0] clr;
  logic [NUM_PLAYERS-1:0] pend_next;
  logic                   found;
  logic [1:0]             sel;
  logic [2:0]             cand;
  logic [2:0]             rr_next;
  logic [4:0]             roll_next;

  function automatic logic [4:0] max_of(input logic [2:0] d);
    case (d)
      3'd0:    return 5'd4;
      3'd1:    return 5'd6;
      3'd2:    return 5'd8;
      3'd3:    return 5'd10;
      3'd4:    return 5'd12;
      default: return 5'd20;
    endcase
  endfunction

  // First pending index at or above rr_ptr, wrapping
  always_comb begin
    found = 1'b0;
    sel   = 2'd0;
    cand  = 3'd0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      cand = {1'b0, rr_ptr} + 3'(k);
      if (cand >= NP) cand = cand - NP;
      if (!found && pending[cand[1:0]]) begin
        found = 1'b1;
        sel   = cand[1:0];
      end
    end
  end

  always_comb begin
    req_edge  = roll_req & ~req_prev;
    clr       = (state == IDLE && found) ? (ONE << sel) : '0;
    pend_next = (pending & ~clr) | req_edge;
    rr_next   = {1'b0, sel} + 3'd1;
    if (rr_next >= NP) rr_next = 3'd0;
    roll_next = (roll_cnt >= max_r) ? 5'd1 : roll_cnt + 5'd1;
  end

  always_comb begin
    tens = 4'd0;
    ones = disp[3:0];
    if (disp >= 5'd20) begin
      tens = 4'd2;
      ones = 4'(disp - 5'd20);
    end else if (disp >= 5'd10) begin
      tens = 4'd1;
      ones = 4'(disp - 5'd10);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      pending       <= '0;
      req_prev      <= '0;
      rr_ptr        <= 2'd0;
      roll_cnt      <= 5'd1;
      max_r         <= 5'd20;
      disp          <= 5'd0;
      tick          <= '0;
      step          <= '0;
      result        <= 5'd0;
      result_player <= 2'd0;
      grant         <= '0;
      busy          <= 1'b0;
      result_valid  <= 1'b0;
    end else begin
      req_prev <= roll_req;
      pending  <= pend_next;
      roll_cnt <= roll_next;
      case (state)
        IDLE: begin
          if (found) begin
            grant         <= ONE << sel;
            result_player <= sel;
            max_r         <= max_of(die_sel);
            rr_ptr        <= rr_next[1:0];
            busy          <= 1'b1;
            state         <= GRANT;
          end
        end
        GRANT: begin
          tick  <= '0;
          step  <= '0;
          state <= TUMBLE;
        end
        TUMBLE: begin
          if (tick == TICK_LAST) begin
            disp <= roll_cnt;
            tick <= '0;
            step <= step + 1'b1;
            if (step == STEP_LAST) begin
              result       <= roll_cnt;
              result_valid <= 1'b1;
              state        <= DONE;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        DONE: begin
          result_valid <= 1'b0;
          grant        <= '0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dice_roll_scheduler.sv
// Directed + randomized bench for dice_roll_scheduler.
// Expectations come from roll-level arbitration and timing rules.
module tb_dice_roll_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] roll_req;
  logic [2:0] die_sel;
  logic       busy;
  logic [3:0] grant;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [4:0] result;
  logic       result_valid;
  logic [1:0] result_player;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic [3:0] m_pend;
  int         m_rr;
  bit         seen [1:20];

  dice_roll_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .roll_req      (roll_req),
    .die_sel       (die_sel),
    .busy          (busy),
    .grant         (grant),
    .tens          (tens),
    .ones          (ones),
    .result        (result),
    .result_valid  (result_valid),
    .result_player (result_player)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int max_of(input logic [2:0] d);
    int t [8] = '{4, 6, 8, 10, 12, 20, 20, 20};
    return t[d];
  endfunction

  function automatic int pick(input logic [3:0] m, input int rr);
    for (int k = 0; k < 4; k++)
      if (m[(rr + k) % 4]) return (rr + k) % 4;
    return -1;
  endfunction

  task automatic set_req(input logic [3:0] m);
    m_pend   = m_pend | (m & ~roll_req);
    roll_req = m;
  endtask

  function automatic logic [20:0] outs();
    return {busy, grant, tens, ones, result, result_valid, result_player};
  endfunction

  task automatic do_reset();
    reset    = 1'b0;
    roll_req = 4'b0;
    m_pend   = 4'b0;
    m_rr     = 0;
    cyc(2);
    reset = 1'b1;
    cyc(1);
  endtask

  task automatic idle_check(input string tag, input int n);
    bit ok = 1'b1;
    repeat (n) begin
      cyc(1);
      if (busy !== 1'b0 || grant !== 4'b0 || result_valid !== 1'b0)
        ok = 1'b0;
    end
    check(tag, ok, 1);
  endtask

  // Called in cycle E (edge just presented, or previous DONE cycle);
  // returns in this roll's DONE cycle.
  task automatic watch_roll(input logic [2:0] die,
                            input int e1k, input logic [3:0] e1r,
                            input int e2k, input logic [3:0] e2r);
    int p, mx, res, dv;
    bit tok, dok;
    logic [3:0] oh;
    p      = pick(m_pend, m_rr);
    m_pend[p] = 1'b0;
    m_rr   = (p + 1) % 4;
    mx     = max_of(die);
    oh     = 4'(1 << p);
    die_sel = die;
    tok    = 1'b1;
    dok    = 1'b1;
    for (int k = 1; k <= 67; k++) begin
      @(posedge clk);
      #1;
      if (k >= 3 && k <= 65) die_sel = 3'($urandom);
      if (k == e1k) set_req(e1r);
      if (k == e2k) set_req(e2r);
      if (grant !== ((k >= 2) ? oh : 4'b0)) tok = 1'b0;
      if (busy !== (k >= 2)) tok = 1'b0;
      if (result_valid !== (k == 67)) tok = 1'b0;
      dv = int'(tens) * 10 + int'(ones);
      if (k >= 7 && !(ones <= 4'd9 && dv >= 1 && dv <= mx)) dok = 1'b0;
    end
    res = int'(result);
    if (res >= 1 && res <= 20) seen[res] = 1'b1;
    check("timing", tok, 1);
    check("disp_range", dok, 1);
    check("player", result_player, p);
    check("result_range", (res >= 1 && res <= mx), 1);
    check("bcd", {tens, ones}, {4'(res / 10), 4'(res % 10)});
  endtask

  initial begin
    bit ok;
    int p, gap;
    reset    = 1'b0;
    roll_req = 4'b0;
    die_sel  = 3'd0;
    m_pend   = 4'b0;
    m_rr     = 0;

    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      roll_req = 4'($urandom);
      die_sel  = 3'($urandom);
      if (outs() !== 21'd0) ok = 1'b0;
    end
    check("reset_zero", ok, 1);
    roll_req = 4'b0;
    cyc(1);
    reset = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (outs() !== 21'd0) ok = 1'b0;
    end
    check("post_reset_zero", ok, 1);

    set_req(4'b0010);
    watch_roll(3'd2, -1, 4'b0, -1, 4'b0);
    cyc(1);
    check("single_busy_low", busy, 0);
    set_req(4'b0);

    do_reset();
    set_req(4'b1101);
    watch_roll(3'd5, -1, 4'b0, -1, 4'b0);
    check("arb_first", result_player, 0);
    watch_roll(3'd1, 10, 4'b0000, -1, 4'b0);
    check("arb_second", result_player, 2);
    watch_roll(3'd3, 20, 4'b1001, -1, 4'b0);
    check("arb_third", result_player, 3);
    watch_roll(3'd4, -1, 4'b0, -1, 4'b0);
    check("arb_wrap", result_player, 0);
    watch_roll(3'd0, -1, 4'b0, -1, 4'b0);
    check("arb_last", result_player, 3);
    idle_check("arb_idle", 10);
    set_req(4'b0);
    cyc(1);

    set_req(4'b0100);
    watch_roll(3'd6, -1, 4'b0, -1, 4'b0);
    idle_check("level_no_retrigger", 140);
    set_req(4'b0);
    cyc(1);
    set_req(4'b0100);
    watch_roll(3'd7, 20, 4'b0000, 30, 4'b0100);
    watch_roll(3'd7, -1, 4'b0, -1, 4'b0);
    idle_check("repress_once", 140);
    set_req(4'b0);
    cyc(1);

    set_req(4'b0010);
    cyc(10);
    set_req(4'b1010);
    cyc(20);
    check("busy_mid_roll", busy, 1);
    reset    = 1'b0;
    roll_req = 4'b0;
    m_pend   = 4'b0;
    m_rr     = 0;
    #1;
    check("async_reset_zero", outs(), 0);
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      die_sel = 3'($urandom);
      if (outs() !== 21'd0) ok = 1'b0;
    end
    check("reset_hold_zero", ok, 1);
    cyc(1);
    reset = 1'b1;
    idle_check("no_roll_after_reset", 80);
    set_req(4'b0010);
    watch_roll(3'd5, -1, 4'b0, -1, 4'b0);
    cyc(1);
    check("post_reset_busy_low", busy, 0);
    set_req(4'b0);

    for (int d = 0; d < 8; d++) begin
      for (int r = 0; r < 40; r++) begin
        gap = $urandom_range(0, 5);
        p   = $urandom_range(0, 3);
        cyc(1 + gap);
        set_req(4'(1 << p));
        watch_roll(3'(d), -1, 4'b0, -1, 4'b0);
        cyc(1);
        check("rand_busy_low", busy, 0);
        set_req(4'b0);
      end
    end

    for (int v = 1; v <= 20; v++)
      check($sformatf("seen_%0d", v), seen[v], 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
